// File: rtl/fre_meas_pkg.sv
// Shared types and constants for the frequency measurement controller.
// FSM encoding, BCD digit types, count limit and default thresholds.
package fre_meas_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GATE = 2'd1,
    ST_CONV = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  typedef logic [3:0] bcd_t;

  typedef struct packed {
    bcd_t thou;
    bcd_t hund;
    bcd_t ten;
    bcd_t one;
  } bcd4_t;

  localparam int             COUNT_W     = 14;
  localparam logic [13:0]    MAX_COUNT   = 14'd9999;
  localparam logic [7:0]     TH_HIGH_DEF = 8'd140;
  localparam logic [7:0]     TH_LOW_DEF  = 8'd115;
  localparam logic [7:0]     LVL_MID     = 8'd128;
  localparam int             BCD_STEPS   = 14;

  // Double-dabble correction: a digit of 5 or more overflows once doubled.
  function automatic bcd_t add3(input bcd_t d);
    return (d >= 4'd5) ? (d + 4'd3) : d;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential 14-bit binary to 4-digit BCD converter (shift-add-3).
// One bit per cycle: done_o is high during the 14th step after start_i.
module bin2bcd_seq
  import fre_meas_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic [COUNT_W-1:0] bin_i,
  output logic               done_o,
  output bcd4_t              digits_o
);

  localparam logic [3:0] LAST_STEP = 4'(BCD_STEPS - 1);

  logic [COUNT_W-1:0] bin_q, bin_d;
  logic [15:0]        bcd_q, bcd_d;
  logic [3:0]         step_q, step_d;
  logic               run_q, run_d;
  logic [15:0]        adj;

  always_comb begin
    adj    = {add3(bcd_q[15:12]), add3(bcd_q[11:8]), add3(bcd_q[7:4]), add3(bcd_q[3:0])};
    bin_d  = bin_q;
    bcd_d  = bcd_q;
    step_d = step_q;
    run_d  = run_q;
    if (start_i) begin
      bin_d  = bin_i;
      bcd_d  = '0;
      step_d = '0;
      run_d  = 1'b1;
    end else if (run_q) begin
      // Shift the corrected BCD word and the binary remainder as one register.
      bcd_d  = {adj[14:0], bin_q[COUNT_W-1]};
      bin_d  = {bin_q[COUNT_W-2:0], 1'b0};
      step_d = step_q + 4'd1;
      if (step_q == LAST_STEP) begin
        run_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q  <= '0;
      bcd_q  <= '0;
      step_q <= '0;
      run_q  <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      bcd_q  <= bcd_d;
      step_q <= step_d;
      run_q  <= run_d;
    end
  end

  assign done_o   = run_q && (step_q == LAST_STEP);
  assign digits_o = bcd4_t'(bcd_q);

endmodule

// File: rtl/fre_meas_ctrl.sv
// Gated frequency counter: counts rising level crossings of wave_in over a gate window,
// converts to BCD and presents four digits. Define FRE_MEAS_HYST_EN for hysteresis thresholds.
module fre_meas_ctrl
  import fre_meas_pkg::*;
#(
  parameter int         GATE_CYCLES = 50000000,
  parameter logic [7:0] TH_HIGH     = TH_HIGH_DEF,
  parameter logic [7:0] TH_LOW      = TH_LOW_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       cont,
  input  logic [7:0] wave_in,
  output logic       busy,
  output logic       valid,
  output logic       ovf,
  output logic [3:0] fre_rea_thou,
  output logic [3:0] fre_rea_hund,
  output logic [3:0] fre_rea_ten,
  output logic [3:0] fre_rea_one
);

  localparam int            GATE_W    = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);

  state_e             state_q, state_d;
  logic [GATE_W-1:0]  gate_cnt_q, gate_cnt_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               ovf_acc_q, ovf_acc_d;
  logic               lvl_q, lvl_d;
  bcd4_t              digits_q, digits_d;
  logic               ovf_q, ovf_d;
  logic               valid_q, valid_d;
  logic               rise;
  logic               conv_start;
  logic               conv_done;
  bcd4_t              conv_digits;

`ifdef FRE_MEAS_HYST_EN
  always_comb begin
    lvl_d = lvl_q;
    if (wave_in >= TH_HIGH) begin
      lvl_d = 1'b1;
    end else if (wave_in <= TH_LOW) begin
      lvl_d = 1'b0;
    end
  end
`else
  always_comb begin
    lvl_d = (wave_in >= LVL_MID);
  end
`endif

  // An event is the 0->1 level change taking effect at the end of this cycle.
  assign rise = lvl_d & ~lvl_q;

  always_comb begin
    state_d    = state_q;
    gate_cnt_d = gate_cnt_q;
    count_d    = count_q;
    ovf_acc_d  = ovf_acc_q;
    digits_d   = digits_q;
    ovf_d      = ovf_q;
    valid_d    = 1'b0;
    conv_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start || cont) begin
          state_d    = ST_GATE;
          gate_cnt_d = '0;
          count_d    = '0;
          ovf_acc_d  = 1'b0;
        end
      end
      ST_GATE: begin
        if (rise) begin
          if (count_q == MAX_COUNT) begin
            ovf_acc_d = 1'b1;
          end else begin
            count_d = count_q + 14'd1;
          end
        end
        if (gate_cnt_q == GATE_LAST) begin
          state_d    = ST_CONV;
          conv_start = 1'b1;
        end else begin
          gate_cnt_d = gate_cnt_q + 1'b1;
        end
      end
      ST_CONV: begin
        if (conv_done) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        digits_d = conv_digits;
        ovf_d    = ovf_acc_q;
        valid_d  = 1'b1;
        if (cont) begin
          state_d    = ST_GATE;
          gate_cnt_d = '0;
          count_d    = '0;
          ovf_acc_d  = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      gate_cnt_q <= '0;
      count_q    <= '0;
      ovf_acc_q  <= 1'b0;
      lvl_q      <= 1'b0;
      digits_q   <= '0;
      ovf_q      <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      gate_cnt_q <= gate_cnt_d;
      count_q    <= count_d;
      ovf_acc_q  <= ovf_acc_d;
      lvl_q      <= lvl_d;
      digits_q   <= digits_d;
      ovf_q      <= ovf_d;
      valid_q    <= valid_d;
    end
  end

  // count_d already includes an event on the final gate cycle.
  bin2bcd_seq u_bin2bcd (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (conv_start),
    .bin_i    (count_d),
    .done_o   (conv_done),
    .digits_o (conv_digits)
  );

  assign busy         = (state_q != ST_IDLE);
  assign valid        = valid_q;
  assign ovf          = ovf_q;
  assign fre_rea_thou = digits_q.thou;
  assign fre_rea_hund = digits_q.hund;
  assign fre_rea_ten  = digits_q.ten;
  assign fre_rea_one  = digits_q.one;

endmodule
